// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline typedefs: ALU opcodes, hazard FSM states, forwarding selects.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Flush counter width: covers FLUSH_CYCLES up to 7 plus the MEM_WAIT save encoding.
    localparam int unsigned FLUSH_CNT_W = 3;
    typedef logic [FLUSH_CNT_W-1:0] fcnt_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-operand forwarding mux select: EX result beats MEM result beats register file.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] ex_wa,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_wa,
    input  logic              mem_reg_we,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_REG;
        if (ex_reg_we && (ex_wa != '0) && (ex_wa == rs) && !ex_is_load) begin
            sel = FWD_EX;
        end else if (mem_reg_we && (mem_wa != '0) && (mem_wa == rs)) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, redirect flush,
// data-memory wait freeze, operand forwarding selects and a stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_wa,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_wa,
    input  logic              mem_reg_we,
    input  logic              ex_redirect,
    input  logic              dmem_busy,
    output logic              pc_hold,
    output logic              s1_hold,
    output logic              s2_hold,
    output logic              s3_hold,
    output logic              s1_flush,
    output logic              s2_flush,
    output fwd_sel_t          fwd_a_sel,
    output fwd_sel_t          fwd_b_sel,
    output hz_state_t         state_o,
    output logic [CNT_W-1:0]  stall_count
);

    hz_state_t  state, next_state, eff_state;
    fcnt_t      cnt, next_cnt, eff_cnt;
    fwd_sel_t   fwd_a_raw, fwd_b_raw;
    logic       load_use;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs         (id_rs1),
        .ex_wa      (ex_wa),
        .ex_reg_we  (ex_reg_we),
        .ex_is_load (ex_is_load),
        .mem_wa     (mem_wa),
        .mem_reg_we (mem_reg_we),
        .sel        (fwd_a_raw)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs         (id_rs2),
        .ex_wa      (ex_wa),
        .ex_reg_we  (ex_reg_we),
        .ex_is_load (ex_is_load),
        .mem_wa     (mem_wa),
        .mem_reg_we (mem_reg_we),
        .sel        (fwd_b_raw)
    );

    assign load_use = ex_is_load && ex_reg_we && (ex_wa != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_wa)) ||
                       (id_use_rs2 && (id_rs2 == ex_wa)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (pc_hold && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    // In MEM_WAIT, cnt holds 0 for a saved RUN, or flush count + 1 for a saved
    // FLUSH; the exit cycle (busy low) behaves exactly as the restored state.
    always_comb begin
        eff_state = state;
        eff_cnt   = cnt;
        if (state == MEM_WAIT) begin
            eff_state = (cnt == '0) ? RUN : FLUSH;
            eff_cnt   = cnt - 1'b1;
        end

        next_state = eff_state;
        next_cnt   = eff_cnt;
        pc_hold    = 1'b0;
        s1_hold    = 1'b0;
        s2_hold    = 1'b0;
        s3_hold    = 1'b0;
        s1_flush   = 1'b0;
        s2_flush   = 1'b0;

        if (dmem_busy) begin
            pc_hold    = 1'b1;
            s1_hold    = 1'b1;
            s2_hold    = 1'b1;
            s3_hold    = 1'b1;
            next_state = MEM_WAIT;
            next_cnt   = (eff_state == FLUSH) ? eff_cnt + 1'b1 : '0;
        end else begin
            case (eff_state)
                FLUSH: begin
                    s1_flush = 1'b1;
                    s2_flush = 1'b1;
                    if (ex_redirect) begin
                        next_cnt = fcnt_t'(FLUSH_CYCLES - 1);
                    end else if (eff_cnt == '0) begin
                        next_state = RUN;
                    end else begin
                        next_cnt = eff_cnt - 1'b1;
                    end
                end
                default: begin
                    next_cnt = '0;
                    if (ex_redirect) begin
                        s1_flush   = 1'b1;
                        s2_flush   = 1'b1;
                        next_cnt   = fcnt_t'(FLUSH_CYCLES - 1);
                        next_state = FLUSH;
                    end else if (load_use) begin
                        pc_hold  = 1'b1;
                        s1_hold  = 1'b1;
                        s2_flush = 1'b1;
                    end
                end
            endcase
        end

        if (!reset) begin
            pc_hold  = 1'b0;
            s1_hold  = 1'b0;
            s2_hold  = 1'b0;
            s3_hold  = 1'b0;
            s1_flush = 1'b0;
            s2_flush = 1'b0;
        end
    end

    assign fwd_a_sel = reset ? fwd_a_raw : FWD_REG;
    assign fwd_b_sel = reset ? fwd_b_raw : FWD_REG;
    assign state_o   = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed checks of pipeline_hazard_ctrl with FLUSH_CYCLES=2 and a 4-bit stall counter.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_rs1, id_rs2, ex_wa, mem_wa;
    logic        id_use_rs1, id_use_rs2, ex_reg_we, ex_is_load, mem_reg_we;
    logic        ex_redirect, dmem_busy;
    logic        pc_hold, s1_hold, s2_hold, s3_hold, s1_flush, s2_flush;
    fwd_sel_t    fwd_a_sel, fwd_b_sel;
    hz_state_t   state_o;
    logic [3:0]  stall_count;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl #(.REG_AW(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_wa       (ex_wa),
        .ex_reg_we   (ex_reg_we),
        .ex_is_load  (ex_is_load),
        .mem_wa      (mem_wa),
        .mem_reg_we  (mem_reg_we),
        .ex_redirect (ex_redirect),
        .dmem_busy   (dmem_busy),
        .pc_hold     (pc_hold),
        .s1_hold     (s1_hold),
        .s2_hold     (s2_hold),
        .s3_hold     (s3_hold),
        .s1_flush    (s1_flush),
        .s2_flush    (s2_flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .state_o     (state_o),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // holds packed as {pc,s1,s2,s3}, flushes as {s1,s2}
    task automatic chk_ctl(input string tag, input logic [3:0] holds, input logic [1:0] flushes);
        chk({tag, "_holds"}, {28'd0, pc_hold, s1_hold, s2_hold, s3_hold}, {28'd0, holds});
        chk({tag, "_flush"}, {30'd0, s1_flush, s2_flush}, {30'd0, flushes});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_wa = '0; ex_reg_we = 0; ex_is_load = 0;
        mem_wa = '0; mem_reg_we = 0; ex_redirect = 0; dmem_busy = 0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        dmem_busy = 1;
        ex_wa = 4'd5; ex_reg_we = 1; id_rs1 = 4'd5;
        #3;
        chk("rst_state", state_o, RUN);
        chk("rst_stall", stall_count, 0);
        chk_ctl("rst", 4'b0000, 2'b00);
        chk("rst_fwd_a", fwd_a_sel, FWD_REG);
        clear_inputs();
        #9 reset = 1'b1;
        tick();

        // load-use on rs1: one bubble, stays RUN
        ex_is_load = 1; ex_reg_we = 1; ex_wa = 4'd3; id_rs1 = 4'd3; id_use_rs1 = 1;
        #1;
        chk_ctl("lu", 4'b1100, 2'b01);
        chk("lu_state", state_o, RUN);
        chk("lu_fwd_a", fwd_a_sel, FWD_REG);
        tick();
        clear_inputs();
        #1;
        chk("lu_after_state", state_o, RUN);
        chk("lu_after_stall", stall_count, 1);
        chk_ctl("lu_after", 4'b0000, 2'b00);

        // forwarding priority
        ex_wa = 4'd5; mem_wa = 4'd5; ex_reg_we = 1; mem_reg_we = 1; id_rs2 = 4'd5;
        #1 chk("fwd_ex", fwd_b_sel, FWD_EX);
        chk("fwd_a_rs0", fwd_a_sel, FWD_REG);
        ex_is_load = 1;
        #1 chk("fwd_ex_load", fwd_b_sel, FWD_MEM);
        ex_is_load = 0; ex_wa = 4'd0;
        #1 chk("fwd_mem", fwd_b_sel, FWD_MEM);
        id_rs2 = 4'd0;
        #1 chk("fwd_rs0", fwd_b_sel, FWD_REG);
        clear_inputs();
        tick();

        // redirect: three flush cycles, load-use suppressed in FLUSH
        ex_redirect = 1;
        #1 chk_ctl("rd0", 4'b0000, 2'b11);
        tick();
        ex_redirect = 0;
        chk("rd1_state", state_o, FLUSH);
        chk_ctl("rd1", 4'b0000, 2'b11);
        tick();
        ex_is_load = 1; ex_reg_we = 1; ex_wa = 4'd3; id_rs1 = 4'd3; id_use_rs1 = 1;
        #1;
        chk("rd2_state", state_o, FLUSH);
        chk_ctl("rd2_lu_suppressed", 4'b0000, 2'b11);
        clear_inputs();
        tick();
        chk("rd3_state", state_o, RUN);
        chk_ctl("rd3", 4'b0000, 2'b00);
        chk("rd3_stall", stall_count, 1);

        // dmem_busy for 4 cycles mid-FLUSH with counter=1
        ex_redirect = 1;
        tick();
        ex_redirect = 0;
        dmem_busy = 1;
        #1;
        chk("mw0_state", state_o, FLUSH);
        chk_ctl("mw0", 4'b1111, 2'b00);
        for (int i = 1; i < 4; i++) begin
            tick();
            ex_redirect = (i == 2);
            #1;
            chk("mw_state", state_o, MEM_WAIT);
            chk_ctl("mw", 4'b1111, 2'b00);
        end
        tick();
        ex_redirect = 0; dmem_busy = 0;
        #1;
        chk("mw_exit_stall", stall_count, 5);
        chk_ctl("mw_exit", 4'b0000, 2'b11);
        tick();
        chk("mw_f2_state", state_o, FLUSH);
        chk_ctl("mw_f2", 4'b0000, 2'b11);
        tick();
        chk("mw_done_state", state_o, RUN);
        chk_ctl("mw_done", 4'b0000, 2'b00);

        // saturation: 20 stall cycles on a 4-bit counter
        dmem_busy = 1;
        repeat (20) tick();
        dmem_busy = 0;
        #1;
        chk("sat_stall", stall_count, 15);
        chk("sat_exit_state", state_o, MEM_WAIT);
        chk_ctl("sat_exit", 4'b0000, 2'b00);
        tick();
        chk("sat_run", state_o, RUN);
        chk("sat_hold", stall_count, 15);

        // asynchronous reset mid-MEM_WAIT
        dmem_busy = 1;
        tick();
        chk("pre_rst_state", state_o, MEM_WAIT);
        ex_wa = 4'd5; ex_reg_we = 1; id_rs1 = 4'd5;
        #1 chk("pre_rst_fwd", fwd_a_sel, FWD_EX);
        reset = 1'b0;
        #1;
        chk("arst_state", state_o, RUN);
        chk("arst_stall", stall_count, 0);
        chk_ctl("arst", 4'b0000, 2'b00);
        chk("arst_fwd_a", fwd_a_sel, FWD_REG);
        clear_inputs();
        #1 reset = 1'b1;
        tick();
        chk("post_rst_state", state_o, RUN);
        chk("post_rst_stall", stall_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
